// File: rtl/cmos_cfg_pkg.sv
// Shared types and table encoding for the CMOS sensor configuration sequencer.
package cmos_cfg_pkg;

    typedef enum logic [3:0] {
        StCmosRst,
        StCmosWait,
        StFetch,
        StIssue,
        StWaitRsp,
        StVerifyIssue,
        StVerifyWait,
        StDelay,
        StDone,
        StError
    } cfg_state_e;

    typedef struct packed {
        logic [7:0] reg_addr;
        logic [7:0] data;
    } cfg_entry_t;

    localparam logic [7:0] CFG_END_REG   = 8'hFF;
    localparam logic [7:0] CFG_END_DATA  = 8'hFF;
    localparam logic [7:0] CFG_DELAY_REG = 8'hFE;

    function automatic logic cfg_is_end(cfg_entry_t e);
        return (e.reg_addr == CFG_END_REG) && (e.data == CFG_END_DATA);
    endfunction

    function automatic logic cfg_is_delay(cfg_entry_t e);
        return e.reg_addr == CFG_DELAY_REG;
    endfunction

endpackage

// File: rtl/cmos_cfg_rom.sv
// Sensor init table: synchronous ROM, one-cycle read latency, indexed by entry number.
module cmos_cfg_rom
    import cmos_cfg_pkg::*;
#(
    parameter int unsigned Depth = 128,
    localparam int unsigned IdxW = $clog2(Depth)
) (
    input  logic            clk_i,
    input  logic [IdxW-1:0] addr_i,
    output cfg_entry_t      entry_o
);

    cfg_entry_t rd_entry;

    // Soft reset, settle delay, then clock prescaler and scaling setup.
    always_comb begin
        rd_entry = '{reg_addr: CFG_END_REG, data: CFG_END_DATA};
        case (addr_i)
            IdxW'(0): rd_entry = '{reg_addr: 8'h12, data: 8'h80};
            IdxW'(1): rd_entry = '{reg_addr: CFG_DELAY_REG, data: 8'h05};
            IdxW'(2): rd_entry = '{reg_addr: 8'h11, data: 8'h01};
            IdxW'(3): rd_entry = '{reg_addr: 8'h3A, data: 8'h04};
            default: ;
        endcase
    end

    always_ff @(posedge clk_i) begin
        entry_o <= rd_entry;
    end

endmodule

// File: rtl/cmos_config_sequencer.sv
// Walks the sensor init table and issues I2C write commands with retry and error report.
// Optional readback verification is built when CMOS_CFG_VERIFY_EN is defined.
module cmos_config_sequencer
    import cmos_cfg_pkg::*;
#(
    parameter logic [6:0]  DEV_ADDR          = 7'h21,
    parameter int unsigned ROM_DEPTH         = 128,
    parameter int unsigned MAX_RETRY         = 3,
    parameter int unsigned RESET_CYCLES      = 100_000,
    parameter int unsigned POWERUP_CYCLES    = 300_000,
    parameter int unsigned DELAY_UNIT_CYCLES = 100_000,
    localparam int unsigned IdxW             = $clog2(ROM_DEPTH)
) (
    input  logic            clk_i,
    input  logic            reset_ni,
    input  logic            start_i,
    output logic            reset_cmos_o,
    output logic            cmd_valid_o,
    input  logic            cmd_ready_i,
    output logic            cmd_read_o,
    output logic [6:0]      cmd_dev_o,
    output logic [7:0]      cmd_reg_o,
    output logic [7:0]      cmd_data_o,
    input  logic            rsp_valid_i,
    input  logic            rsp_nack_i,
    input  logic [7:0]      rsp_data_i,
    output logic            busy_o,
    output logic            done_o,
    output logic            error_o,
    output logic [IdxW-1:0] err_index_o
);

    localparam int unsigned RetryW = $clog2(MAX_RETRY + 2);

    cfg_state_e        state_q, state_d;
    logic [31:0]       cnt_q, cnt_d;
    logic [IdxW-1:0]   idx_q, idx_d;
    logic [RetryW-1:0] retry_q, retry_d;
    logic              reset_cmos_q, reset_cmos_d;
    logic              cmd_valid_q, cmd_valid_d;
    logic              cmd_read_q, cmd_read_d;
    logic [7:0]        cmd_reg_q, cmd_reg_d;
    logic [7:0]        cmd_data_q, cmd_data_d;
    logic              done_q, done_d;
    logic              error_q, error_d;
    logic [IdxW-1:0]   err_index_q, err_index_d;
    logic              advance, retry_req;
    cfg_entry_t        rom_entry;

    // Addressed by the next index so the entry is ready in the FETCH cycle.
    cmos_cfg_rom #(
        .Depth(ROM_DEPTH)
    ) u_rom (
        .clk_i  (clk_i),
        .addr_i (idx_d),
        .entry_o(rom_entry)
    );

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        idx_d        = idx_q;
        retry_d      = retry_q;
        reset_cmos_d = reset_cmos_q;
        cmd_valid_d  = cmd_valid_q;
        cmd_read_d   = cmd_read_q;
        cmd_reg_d    = cmd_reg_q;
        cmd_data_d   = cmd_data_q;
        done_d       = done_q;
        error_d      = error_q;
        err_index_d  = err_index_q;
        advance      = 1'b0;
        retry_req    = 1'b0;

        case (state_q)
            StCmosRst: begin
                if (cnt_q == '0) begin
                    state_d      = StCmosWait;
                    cnt_d        = POWERUP_CYCLES - 32'd1;
                    reset_cmos_d = 1'b1;
                end else begin
                    cnt_d = cnt_q - 32'd1;
                end
            end
            StCmosWait: begin
                if (cnt_q == '0) begin
                    state_d = StFetch;
                    idx_d   = '0;
                    retry_d = '0;
                end else begin
                    cnt_d = cnt_q - 32'd1;
                end
            end
            StFetch: begin
                if (cfg_is_end(rom_entry)) begin
                    state_d = StDone;
                    done_d  = 1'b1;
                end else if (cfg_is_delay(rom_entry)) begin
                    if (rom_entry.data == 8'h00) begin
                        advance = 1'b1;
                    end else begin
                        state_d = StDelay;
                        cnt_d   = 32'(rom_entry.data) * DELAY_UNIT_CYCLES - 32'd1;
                    end
                end else begin
                    state_d     = StIssue;
                    cmd_valid_d = 1'b1;
                    cmd_reg_d   = rom_entry.reg_addr;
                    cmd_data_d  = rom_entry.data;
                end
            end
            StIssue: begin
                if (cmd_ready_i) begin
                    state_d     = StWaitRsp;
                    cmd_valid_d = 1'b0;
                end
            end
            StWaitRsp: begin
                if (rsp_valid_i) begin
                    if (rsp_nack_i) begin
                        retry_req = 1'b1;
                    end else begin
`ifdef CMOS_CFG_VERIFY_EN
                        state_d     = StVerifyIssue;
                        cmd_valid_d = 1'b1;
                        cmd_read_d  = 1'b1;
`else
                        advance = 1'b1;
`endif
                    end
                end
            end
`ifdef CMOS_CFG_VERIFY_EN
            StVerifyIssue: begin
                if (cmd_ready_i) begin
                    state_d     = StVerifyWait;
                    cmd_valid_d = 1'b0;
                end
            end
            StVerifyWait: begin
                if (rsp_valid_i) begin
                    cmd_read_d = 1'b0;
                    if (rsp_nack_i || (rsp_data_i != cmd_data_q)) begin
                        retry_req = 1'b1;
                    end else begin
                        advance = 1'b1;
                    end
                end
            end
`endif
            StDelay: begin
                if (cnt_q == '0) begin
                    advance = 1'b1;
                end else begin
                    cnt_d = cnt_q - 32'd1;
                end
            end
            StDone, StError: begin
                if (start_i) begin
                    state_d      = StCmosRst;
                    cnt_d        = RESET_CYCLES - 32'd1;
                    reset_cmos_d = 1'b0;
                    done_d       = 1'b0;
                    error_d      = 1'b0;
                    err_index_d  = '0;
                end
            end
            default: ;
        endcase

        // A failed attempt always repeats the write, never just the readback.
        if (retry_req) begin
            cmd_read_d = 1'b0;
            if (32'(retry_q) >= MAX_RETRY) begin
                state_d     = StError;
                error_d     = 1'b1;
                err_index_d = idx_q;
            end else begin
                state_d     = StIssue;
                retry_d     = retry_q + RetryW'(1);
                cmd_valid_d = 1'b1;
            end
        end

        if (advance) begin
            retry_d = '0;
            if (idx_q == IdxW'(ROM_DEPTH - 1)) begin
                state_d = StDone;
                done_d  = 1'b1;
            end else begin
                state_d = StFetch;
                idx_d   = idx_q + IdxW'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q      <= StCmosRst;
            cnt_q        <= RESET_CYCLES - 32'd1;
            idx_q        <= '0;
            retry_q      <= '0;
            reset_cmos_q <= 1'b0;
            cmd_valid_q  <= 1'b0;
            cmd_read_q   <= 1'b0;
            cmd_reg_q    <= '0;
            cmd_data_q   <= '0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
            err_index_q  <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            retry_q      <= retry_d;
            reset_cmos_q <= reset_cmos_d;
            cmd_valid_q  <= cmd_valid_d;
            cmd_read_q   <= cmd_read_d;
            cmd_reg_q    <= cmd_reg_d;
            cmd_data_q   <= cmd_data_d;
            done_q       <= done_d;
            error_q      <= error_d;
            err_index_q  <= err_index_d;
        end
    end

`ifndef CMOS_CFG_VERIFY_EN
    logic unused_rsp_data;
    assign unused_rsp_data = ^rsp_data_i;
`endif

    assign reset_cmos_o = reset_cmos_q;
    assign cmd_valid_o  = cmd_valid_q;
    assign cmd_read_o   = cmd_read_q;
    assign cmd_dev_o    = DEV_ADDR;
    assign cmd_reg_o    = cmd_reg_q;
    assign cmd_data_o   = cmd_data_q;
    assign done_o       = done_q;
    assign error_o      = error_q;
    assign err_index_o  = err_index_q;
    assign busy_o       = (state_q != StDone) && (state_q != StError);

endmodule

// File: tb/tb_cmos_config_sequencer.sv
// Directed bench for cmos_config_sequencer against the built-in table
// {12,80},{FE,05},{11,01},{3A,04},{FF,FF} with short reset/power-up/delay timings.
module tb_cmos_config_sequencer;

    logic       clk = 1'b0;
    logic       reset_ni = 1'b0;
    logic       start_i = 1'b0;
    logic       reset_cmos_o;
    logic       cmd_valid_o;
    logic       cmd_ready_i = 1'b0;
    logic       cmd_read_o;
    logic [6:0] cmd_dev_o;
    logic [7:0] cmd_reg_o;
    logic [7:0] cmd_data_o;
    logic       rsp_valid_i = 1'b0;
    logic       rsp_nack_i = 1'b0;
    logic [7:0] rsp_data_i = 8'h00;
    logic       busy_o;
    logic       done_o;
    logic       error_o;
    logic [6:0] err_index_o;

    int total = 0;
    int bad = 0;
    int last_wait = 0;

    always #5 clk = ~clk;

    cmos_config_sequencer #(
        .RESET_CYCLES     (20),
        .POWERUP_CYCLES   (30),
        .DELAY_UNIT_CYCLES(10)
    ) dut (
        .clk_i       (clk),
        .reset_ni    (reset_ni),
        .start_i     (start_i),
        .reset_cmos_o(reset_cmos_o),
        .cmd_valid_o (cmd_valid_o),
        .cmd_ready_i (cmd_ready_i),
        .cmd_read_o  (cmd_read_o),
        .cmd_dev_o   (cmd_dev_o),
        .cmd_reg_o   (cmd_reg_o),
        .cmd_data_o  (cmd_data_o),
        .rsp_valid_i (rsp_valid_i),
        .rsp_nack_i  (rsp_nack_i),
        .rsp_data_i  (rsp_data_i),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .error_o     (error_o),
        .err_index_o (err_index_o)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_vals(input string p);
        check({p, "_reset_cmos"}, 32'(reset_cmos_o), 0);
        check({p, "_valid"}, 32'(cmd_valid_o), 0);
        check({p, "_read"}, 32'(cmd_read_o), 0);
        check({p, "_reg"}, 32'(cmd_reg_o), 0);
        check({p, "_data"}, 32'(cmd_data_o), 0);
        check({p, "_dev"}, 32'(cmd_dev_o), 32'h21);
        check({p, "_busy"}, 32'(busy_o), 1);
        check({p, "_done"}, 32'(done_o), 0);
        check({p, "_error"}, 32'(error_o), 0);
        check({p, "_err_index"}, 32'(err_index_o), 0);
    endtask

    // Counts rising clock edges after reset release until the sensor reset is lifted.
    task automatic measure_reset(input string tag);
        int n = 0;
        while (reset_cmos_o === 1'b0 && n < 1000) begin
            @(posedge clk);
            #1;
            n++;
        end
        check(tag, n, 20);
        @(negedge clk);
    endtask

    // Waits for a command, checks its fields, then accepts it.
    task automatic do_cmd(input string tag, input logic [7:0] r, input logic [7:0] d);
        int n = 0;
        while (cmd_valid_o !== 1'b1 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        last_wait = n;
        check({tag, "_valid"}, 32'(cmd_valid_o), 1);
        check({tag, "_reg"}, 32'(cmd_reg_o), 32'(r));
        check({tag, "_data"}, 32'(cmd_data_o), 32'(d));
        check({tag, "_dev"}, 32'(cmd_dev_o), 32'h21);
        check({tag, "_read"}, 32'(cmd_read_o), 0);
        cmd_ready_i = 1'b1;
        @(negedge clk);
        cmd_ready_i = 1'b0;
        check({tag, "_drop"}, 32'(cmd_valid_o), 0);
    endtask

    task automatic pulse_rsp(input logic nack);
        rsp_valid_i = 1'b1;
        rsp_nack_i  = nack;
        @(negedge clk);
        rsp_valid_i = 1'b0;
        rsp_nack_i  = 1'b0;
    endtask

    task automatic check_done(input string tag);
        repeat (2) @(negedge clk);
        check({tag, "_done"}, 32'(done_o), 1);
        check({tag, "_busy"}, 32'(busy_o), 0);
        check({tag, "_error"}, 32'(error_o), 0);
        check({tag, "_valid"}, 32'(cmd_valid_o), 0);
    endtask

    task automatic pulse_start();
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
    endtask

    initial begin
        #400_000;
        $display("FAIL global_timeout: observed=running expected=finished");
        $fatal(1, "bench timeout");
    end

    initial begin
        logic seen;
        logic stable;

        // Power-on reset state and the full table walk, including the 5-unit delay.
        repeat (2) @(negedge clk);
        check_reset_vals("por");
        reset_ni = 1'b1;
        measure_reset("por_reset_len");
        do_cmd("a_e0", 8'h12, 8'h80);
        pulse_rsp(1'b0);
        do_cmd("a_e2", 8'h11, 8'h01);
        // FETCH of the delay entry, then 5*10 DELAY cycles, then FETCH, then ISSUE.
        check("a_delay_wait", last_wait, 2 + 5 * 10);
        pulse_rsp(1'b0);
        do_cmd("a_e3", 8'h3A, 8'h04);
        // ACK cycle advances, then FETCH, then ISSUE.
        check("a_ack_wait", last_wait, 1);
        pulse_rsp(1'b0);
        check_done("a_end");

        // Single NACK on 11/01 is retried and the run still completes.
        pulse_start();
        check("b_done_clr", 32'(done_o), 0);
        check("b_busy", 32'(busy_o), 1);
        check("b_reset_cmos", 32'(reset_cmos_o), 0);
        do_cmd("b_e0", 8'h12, 8'h80);
        pulse_rsp(1'b0);
        do_cmd("b_e2", 8'h11, 8'h01);
        pulse_rsp(1'b1);
        do_cmd("b_e2_retry", 8'h11, 8'h01);
        pulse_rsp(1'b0);
        do_cmd("b_e3", 8'h3A, 8'h04);
        pulse_rsp(1'b0);
        check_done("b_end");

        // Four NACKs on entry 2 exhaust the retries.
        pulse_start();
        do_cmd("c_e0", 8'h12, 8'h80);
        pulse_rsp(1'b0);
        for (int i = 0; i < 4; i++) begin
            do_cmd($sformatf("c_e2_try%0d", i), 8'h11, 8'h01);
            pulse_rsp(1'b1);
        end
        check("c_error", 32'(error_o), 1);
        check("c_err_index", 32'(err_index_o), 2);
        check("c_busy", 32'(busy_o), 0);
        check("c_done", 32'(done_o), 0);
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (cmd_valid_o !== 1'b0) seen = 1'b1;
        end
        check("c_no_cmd_after_error", 32'(seen), 0);
        pulse_start();
        check("c_error_clr", 32'(error_o), 0);
        check("c_err_index_clr", 32'(err_index_o), 0);
        check("c_busy_restart", 32'(busy_o), 1);
        do_cmd("c2_e0", 8'h12, 8'h80);
        pulse_rsp(1'b0);
        do_cmd("c2_e2", 8'h11, 8'h01);
        pulse_rsp(1'b0);
        do_cmd("c2_e3", 8'h3A, 8'h04);
        pulse_rsp(1'b0);
        check_done("c2_end");

        // Stalled handshake keeps the command stable; async reset mid-stall restarts.
        pulse_start();
        begin
            int n = 0;
            while (cmd_valid_o !== 1'b1 && n < 2000) begin
                @(negedge clk);
                n++;
            end
        end
        stable = 1'b1;
        repeat (100) begin
            @(negedge clk);
            if (cmd_valid_o !== 1'b1 || cmd_reg_o !== 8'h12 || cmd_data_o !== 8'h80) begin
                stable = 1'b0;
            end
        end
        check("d_stall_stable", 32'(stable), 1);
        #1;
        reset_ni = 1'b0;
        #1;
        check_reset_vals("d_mid");
        @(negedge clk);
        reset_ni = 1'b1;
        measure_reset("d_reset_len");
        do_cmd("d_e0", 8'h12, 8'h80);
        pulse_rsp(1'b0);
        do_cmd("d_e2", 8'h11, 8'h01);
        pulse_rsp(1'b0);
        do_cmd("d_e3", 8'h3A, 8'h04);
        pulse_rsp(1'b0);
        check_done("d_end");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
